// File: rtl/johnson_display_scan.sv
// johnson_display_scan: time-multiplexed six-digit 7-segment driver for Johnson-coded time digits.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks the H1 digit when its frame code is zero.
`default_nettype none

module johnson_display_scan #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] H_out1_johnson,
    input  logic [9:0] H_out0_johnson,
    input  logic [9:0] M_out1_johnson,
    input  logic [9:0] M_out0_johnson,
    input  logic [9:0] S_out1_johnson,
    input  logic [9:0] S_out0_johnson,
    input  logic       reg_0_15s,
    input  logic       reg_15_30s,
    input  logic       reg_30_45s,
    input  logic       reg_45_59s,
    input  logic       err_clr,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic [3:0] quarter_led,
    output logic       err
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SEG_DASH;
        endcase
    endfunction

    logic [PW-1:0] ps_q, ps_d;
    logic [2:0]    idx_q, idx_d;
    logic [9:0]    frame_q [6];
    logic [9:0]    frame_d [6];
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [5:0]    an_q, an_d;
    logic [3:0]    ql_q, ql_d;
    logic          err_q, err_d;

    logic          active;
    logic          snap;
    logic [9:0]    code;
    logic          code_valid;
    logic [3:0]    code_num;

    assign active = (ps_q != '0);
    assign snap   = (ps_q == '0) && (idx_q == 3'd0);

    always_comb begin
        ps_d  = ps_q;
        idx_d = idx_q;
        if (ps_q == PS_LAST) begin
            ps_d  = '0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end else begin
            ps_d  = ps_q + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 6; i++) frame_d[i] = frame_q[i];
        if (snap) begin
            frame_d[0] = H_out1_johnson;
            frame_d[1] = H_out0_johnson;
            frame_d[2] = M_out1_johnson;
            frame_d[3] = M_out0_johnson;
            frame_d[4] = S_out1_johnson;
            frame_d[5] = S_out0_johnson;
        end
    end

    always_comb begin
        case (idx_q)
            3'd0:    code = frame_q[0];
            3'd1:    code = frame_q[1];
            3'd2:    code = frame_q[2];
            3'd3:    code = frame_q[3];
            3'd4:    code = frame_q[4];
            3'd5:    code = frame_q[5];
            default: code = 10'h000;
        endcase
    end

    // Legal codes are exactly 2^d-1 for d=0..9; everything else is rejected.
    always_comb begin
        code_valid = 1'b0;
        code_num   = 4'd0;
        for (int d = 0; d < 10; d++) begin
            if (code == 10'((1 << d) - 1)) begin
                code_valid = 1'b1;
                code_num   = 4'(d);
            end
        end
    end

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = 6'h3F;
        dp_d  = 1'b1;
        if (active) begin
            an_d  = ~(6'b100000 >> idx_q);
            seg_d = code_valid ? seg_of(code_num) : SEG_DASH;
            dp_d  = ~((idx_q == 3'd1) || (idx_q == 3'd3));
`ifdef LEADING_ZERO_BLANK_EN
            if ((idx_q == 3'd0) && (code == 10'h000)) seg_d = SEG_BLANK;
`endif
        end
        err_d = (active && !code_valid) || (err_q && !err_clr);
        ql_d  = {reg_45_59s, reg_30_45s, reg_15_30s, reg_0_15s};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_q  <= '0;
            idx_q <= 3'd0;
            for (int i = 0; i < 6; i++) frame_q[i] <= 10'h000;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= 6'h3F;
            ql_q  <= 4'h0;
            err_q <= 1'b0;
        end else begin
            ps_q  <= ps_d;
            idx_q <= idx_d;
            for (int i = 0; i < 6; i++) frame_q[i] <= frame_d[i];
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
            ql_q  <= ql_d;
            err_q <= err_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign quarter_led = ql_q;
    assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_johnson_display_scan.sv
// Scoreboard bench for johnson_display_scan: a cycle-count reference model queues expected outputs.
`default_nettype none

module tb_johnson_display_scan;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] dig [6];
    logic [3:0] flags = 4'h0;
    logic       clr = 1'b0;

    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic [3:0] quarter_led;
    logic       err;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [5:0] an;
        logic [3:0] ql;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: cycles since reset release, latched frame, sticky error.
    int         k = 0;
    logic [9:0] m_frame [6];
    logic       m_err = 1'b0;

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    johnson_display_scan #(.SCAN_DIV(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .H_out1_johnson (dig[0]),
        .H_out0_johnson (dig[1]),
        .M_out1_johnson (dig[2]),
        .M_out0_johnson (dig[3]),
        .S_out1_johnson (dig[4]),
        .S_out0_johnson (dig[5]),
        .reg_0_15s      (flags[0]),
        .reg_15_30s     (flags[1]),
        .reg_30_45s     (flags[2]),
        .reg_45_59s     (flags[3]),
        .err_clr        (clr),
        .seg            (seg),
        .dp             (dp),
        .an             (an),
        .quarter_led    (quarter_led),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    function automatic int digit_of(input logic [9:0] c);
        for (int d = 0; d < 10; d++) if (c == 10'((1 << d) - 1)) return d;
        return -1;
    endfunction

    // Advance one clock: expectation for the edge that closes cycle k is queued at that edge.
    task automatic step();
        exp_t e;
        int   phase, slot, d;
        phase = k % N;
        slot  = (k / N) % 6;
        e.seg = 7'h7F; e.an = 6'h3F; e.dp = 1'b1;
        d = digit_of(m_frame[slot]);
        if (phase != 0) begin
            e.an  = 6'h3F ^ (6'h01 << (5 - slot));
            e.seg = (d >= 0) ? seg_tbl[d] : 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
            if (slot == 0 && m_frame[0] == 10'h000) e.seg = 7'h7F;
`endif
            e.dp  = !(slot == 1 || slot == 3);
        end
        m_err = ((phase != 0) && (d < 0)) || (m_err && !clr);
        e.err = m_err;
        e.ql  = flags;
        if (phase == 0 && slot == 0) for (int i = 0; i < 6; i++) m_frame[i] = dig[i];
        @(posedge clk);
        exp_q.push_back(e);
        k++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_seg"}, int'(seg), 'h7F);
        check({tag, "_dp"},  int'(dp), 1);
        check({tag, "_an"},  int'(an), 'h3F);
        check({tag, "_ql"},  int'(quarter_led), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        k = 0;
        m_err = 1'b0;
        for (int i = 0; i < 6; i++) m_frame[i] = 10'h000;
    endtask

    function automatic logic [9:0] rand_code();
        if ($urandom_range(0, 9) < 8) return 10'((1 << $urandom_range(0, 9)) - 1);
        return 10'($urandom);
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("seg", int'(seg), int'(e.seg));
            check("dp",  int'(dp),  int'(e.dp));
            check("an",  int'(an),  int'(e.an));
            check("quarter_led", int'(quarter_led), int'(e.ql));
            check("err", int'(err), int'(e.err));
        end
    end

    initial begin
        for (int i = 0; i < 6; i++) dig[i] = 10'h000;
        flags = 4'b1111;
        clr   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_values("held_reset");
        end
        release_reset();

        // 15:30:00, with the quarter flag showing 15..30
        dig[0] = 10'h001; dig[1] = 10'h01F; dig[2] = 10'h007;
        dig[3] = 10'h000; dig[4] = 10'h000; dig[5] = 10'h000;
        flags  = 4'b0010;
        run(6 * N + 2 * N + 1);
        // S0 changes during slot 2: old value must persist until the next snapshot
        dig[5] = 10'h001;
        run(2 * 6 * N);

        // Invalid M0, clear attempted while still invalid, then fixed and cleared
        dig[3] = 10'h005;
        run(6 * N + 4 * N);
        clr = 1'b1; run(1); clr = 1'b0;
        run(N);
        dig[3] = 10'h000;
        run(2 * 6 * N);
        clr = 1'b1; run(1); clr = 1'b0;
        run(6 * N);

        // Leading zero H1
        dig[0] = 10'h000;
        run(2 * 6 * N);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) dig[$urandom_range(0, 5)] = rand_code();
            flags = 4'($urandom);
            clr   = ($urandom_range(0, 9) == 0);
            step();
        end
        clr = 1'b0;

        // Asynchronous reset mid-slot
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        check_reset_values("async_reset_hold");
        check("queue_drained_at_reset", exp_q.size(), 0);
        exp_q.delete();
        release_reset();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) dig[$urandom_range(0, 5)] = rand_code();
            flags = 4'($urandom);
            clr   = ($urandom_range(0, 9) == 0);
            step();
        end
        @(negedge clk);
        #1;
        check("queue_drained_at_end", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
